// File: rtl/mem_arbiter.sv
// Two-master arbiter between icache/dcache and a single-ported RAM.
// The dcache wins by default, but an icache request is served after at most MAX_DSTREAK dcache completions.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W       = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arbState;

  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

  arbState          stateReg, stateNext;
  logic [CNT_W-1:0] dstreakReg, dstreakNext;
  logic             dReq, iReq, ramAccess;

  assign dReq      = dREN | dWEN;
  assign iReq      = iREN;
  assign ramAccess = (ramstate == RAM_ACCESS);

  // Only a saturated streak with the icache waiting lets it jump the queue.
  function automatic arbState arbitrate(input logic d, input logic i,
                                        input logic [CNT_W-1:0] streak);
    if (d && !(i && streak == STREAK_MAX))
      return DGRANT;
    else if (i)
      return IGRANT;
    else
      return IDLE;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateReg   <= IDLE;
      dstreakReg <= '0;
    end else begin
      stateReg   <= stateNext;
      dstreakReg <= dstreakNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    dstreakNext = dstreakReg;
    case (stateReg)
      IDLE: stateNext = arbitrate(dReq, iReq, dstreakReg);
      DGRANT: begin
        if (ramAccess) begin
          if (!iReq)
            dstreakNext = '0;
          else if (dstreakReg == STREAK_MAX)
            dstreakNext = STREAK_MAX;
          else
            dstreakNext = dstreakReg + CNT_W'(1);
          stateNext = arbitrate(dReq, iReq, dstreakNext);
        end else if (!dReq) begin
          stateNext = arbitrate(dReq, iReq, dstreakReg);
        end
      end
      IGRANT: begin
        if (ramAccess) begin
          dstreakNext = '0;
          stateNext   = arbitrate(dReq, iReq, '0);
        end else if (!iReq) begin
          stateNext = arbitrate(dReq, iReq, dstreakReg);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs follow the owner's live enables so a withdrawal drops them at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iReq;
    dwait    = dReq;
    case (stateReg)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = dReq & ~ramAccess;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = iReq & ~ramAccess;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule
